// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch (IF) and load/store (LS).
// LS has priority, and a starvation counter guarantees that a pending fetch eventually wins.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no transaction in flight; arbitrate on every cycle
//   REQ     | mem_req_o high with latched fields; waiting for mem_gnt_i
//   WAIT    | address accepted; waiting for mem_rvalid_i, then arbitrate
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [DATA_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned        CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic [CNT_W-1:0]    starve_cnt_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [3:0]          mem_be_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                arb_window;
    logic                starve_full;
    logic                if_win;
    logic                ls_win;

    // A completing response frees the port in the same cycle, so the next winner is picked then.
    always_comb begin
        arb_window  = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && mem_rvalid_i);
        starve_full = (starve_cnt_q == LIMIT_C);
        if_win      = if_req_i && (!ls_req_i || starve_full);
        ls_win      = ls_req_i && !if_win;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i) begin
            starve_cnt_d = '0;
        end else if (arb_window && if_win) begin
            starve_cnt_d = '0;
        end else if (arb_window && ls_win && !starve_full) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        state_q   <= ST_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_IDLE, ST_WAIT: begin
                    if (arb_window) begin
                        if (if_win) begin
                            state_q    <= ST_REQ;
                            owner_q    <= OWN_IF;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_be_q   <= 4'hF;
                            mem_addr_q <= if_addr_i;
                        end else if (ls_win) begin
                            state_q     <= ST_REQ;
                            owner_q     <= OWN_LS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ls_we_i;
                            mem_be_q    <= ls_be_i;
                            mem_addr_q  <= ls_addr_i;
                            mem_wdata_q <= ls_wdata_i;
                        end else begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Grants and responses are routed combinationally so no cycle is lost in either phase.
    always_comb begin
        if_gnt_o    = (state_q == ST_REQ)  && mem_gnt_i    && (owner_q == OWN_IF);
        ls_gnt_o    = (state_q == ST_REQ)  && mem_gnt_i    && (owner_q == OWN_LS);
        if_rvalid_o = (state_q == ST_WAIT) && mem_rvalid_i && (owner_q == OWN_IF);
        ls_rvalid_o = (state_q == ST_WAIT) && mem_rvalid_i && (owner_q == OWN_LS);
    end

    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, and a simple memory responder.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned W     = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_req_i, ls_req_i, ls_we_i;
    logic [W-1:0] if_addr_i, ls_addr_i, ls_wdata_i;
    logic [3:0]   ls_be_i;
    logic         if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
    logic [W-1:0] if_rdata_o, ls_rdata_o;
    logic         mem_req_o, mem_we_o, busy_o;
    logic [3:0]   mem_be_o;
    logic [W-1:0] mem_addr_o, mem_wdata_o;
    logic         mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [W-1:0] mem_rdata_i = '0;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one pending transaction record plus the starvation count.
    bit         m_busy, m_issued, m_owner_ls, m_we;
    logic [3:0] m_be;
    logic [W-1:0] m_addr, m_wdata;
    int         m_starve;

    always @(posedge clk or negedge rst_n) begin
        bit done;
        bit free;
        if (!rst_n) begin
            m_busy = 0; m_issued = 0; m_owner_ls = 0; m_we = 0;
            m_be = 4'h0; m_addr = '0; m_wdata = '0; m_starve = 0;
        end else begin
            done = m_busy && m_issued && mem_rvalid_i;
            if (m_busy && !m_issued && mem_gnt_i) m_issued = 1;
            free = !m_busy || done;
            if (free) begin
                if (if_req_i && (!ls_req_i || m_starve == LIMIT)) begin
                    m_busy = 1; m_issued = 0; m_owner_ls = 0;
                    m_we = 0; m_be = 4'hF; m_addr = if_addr_i;
                    m_starve = 0;
                end else if (ls_req_i) begin
                    m_busy = 1; m_issued = 0; m_owner_ls = 1;
                    m_we = ls_we_i; m_be = ls_be_i; m_addr = ls_addr_i; m_wdata = ls_wdata_i;
                    if (if_req_i && m_starve < LIMIT) m_starve++;
                end else begin
                    m_busy = 0;
                end
            end
            if (!if_req_i) m_starve = 0;
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        exp_req = m_busy && !m_issued;
        check("mem_req", mem_req_o, exp_req);
        check("busy", busy_o, m_busy);
        check("mem_we", mem_we_o, m_we);
        check("mem_be", mem_be_o, m_be);
        check("mem_addr", mem_addr_o, m_addr);
        check("mem_wdata", mem_wdata_o, m_wdata);
        check("if_gnt", if_gnt_o, exp_req && mem_gnt_i && !m_owner_ls);
        check("ls_gnt", ls_gnt_o, exp_req && mem_gnt_i && m_owner_ls);
        check("if_rvalid", if_rvalid_o, m_busy && m_issued && mem_rvalid_i && !m_owner_ls);
        check("ls_rvalid", ls_rvalid_o, m_busy && m_issued && mem_rvalid_i && m_owner_ls);
        check("if_rdata", if_rdata_o, mem_rdata_i);
        check("ls_rdata", ls_rdata_o, mem_rdata_i);
        check("starve_cnt", 32'(dut.starve_cnt_q), m_starve);
    end

    // Memory responder: grant after gnt_delay cycles of request, rvalid the cycle after grant.
    bit         auto_resp = 1;
    int         gnt_delay = 0;
    int         req_age   = 0;
    bit         gnt_seen  = 0;
    logic [W-1:0] resp_data = '0;
    logic       man_gnt = 0, man_rvalid = 0;
    logic [W-1:0] man_rdata = '0;

    always @(negedge clk) gnt_seen = mem_req_o && mem_gnt_i;

    always @(posedge clk) begin
        #2;
        if (auto_resp) begin
            mem_rvalid_i = gnt_seen;
            mem_rdata_i  = gnt_seen ? resp_data : '0;
            if (mem_req_o) begin
                mem_gnt_i = (req_age >= gnt_delay);
                req_age++;
            end else begin
                mem_gnt_i = 0;
                req_age   = 0;
            end
        end else begin
            mem_gnt_i    = man_gnt;
            mem_rvalid_i = man_rvalid;
            mem_rdata_i  = man_rdata;
            req_age      = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        int n_ls, n_req, n_gnt;
        bit got_if, saw_req;
        rst_n = 0;
        if_req_i = 0; ls_req_i = 0; ls_we_i = 0; ls_be_i = 4'h0;
        if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0;

        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_be", mem_be_o, 4'h0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        next_cycle();

        // Single fetch with immediate grant and response
        resp_data = 32'hDEADBEEF;
        if_req_i = 1; if_addr_i = 32'h100;
        next_cycle();
        @(negedge clk);
        check("t1_mem_req", mem_req_o, 1);
        check("t1_if_gnt", if_gnt_o, 1);
        check("t1_addr", mem_addr_o, 32'h100);
        check("t1_be", mem_be_o, 4'hF);
        next_cycle();
        if_req_i = 0;
        @(negedge clk);
        check("t1_if_rvalid", if_rvalid_o, 1);
        check("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
        check("t1_ls_rvalid", ls_rvalid_o, 0);
        wait_idle("t1_idle");

        // Simultaneous requests: LS store first, IF issued at cycle 3
        next_cycle();
        resp_data = 32'hCAFE0001;
        if_req_i = 1; if_addr_i = 32'h300;
        ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h200; ls_wdata_i = 32'h12345678;
        next_cycle();
        @(negedge clk);
        check("t2_ls_gnt", ls_gnt_o, 1);
        check("t2_if_gnt", if_gnt_o, 0);
        check("t2_we", mem_we_o, 1);
        check("t2_be", mem_be_o, 4'b0011);
        check("t2_addr", mem_addr_o, 32'h200);
        next_cycle();
        ls_req_i = 0;
        @(negedge clk);
        check("t2_ls_rvalid", ls_rvalid_o, 1);
        next_cycle();
        @(negedge clk);
        check("t2_if_req_c3", mem_req_o, 1);
        check("t2_if_gnt_c3", if_gnt_o, 1);
        check("t2_if_addr", mem_addr_o, 32'h300);
        check("t2_if_we", mem_we_o, 0);
        check("t2_if_wdata_hold", mem_wdata_o, 32'h12345678);
        next_cycle();
        if_req_i = 0; ls_we_i = 0;
        wait_idle("t2_idle");

        // Starvation: LS held continuously, IF wins after LIMIT LS wins
        next_cycle();
        if_req_i = 1; if_addr_i = 32'h400;
        ls_req_i = 1; ls_be_i = 4'hF; ls_addr_i = 32'h500; ls_wdata_i = 32'h0BADF00D;
        n_ls = 0; got_if = 0;
        for (int c = 0; c < 60 && !got_if; c++) begin
            @(negedge clk);
            if (ls_gnt_o) n_ls++;
            if (if_gnt_o) got_if = 1;
        end
        check("t3_if_won", got_if, 1);
        check("t3_ls_wins", n_ls, LIMIT);
        check("t3_starve_clr", 32'(dut.starve_cnt_q), 0);
        next_cycle();
        if_req_i = 0; ls_req_i = 0;
        wait_idle("t3_idle");

        // Delayed grant: request held stable for 4 cycles, one grant pulse
        next_cycle();
        gnt_delay = 3;
        ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'hC; ls_addr_i = 32'h600; ls_wdata_i = 32'hA5A5A5A5;
        n_req = 0; n_gnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req_o) n_req++;
            if (ls_gnt_o) begin
                n_gnt++;
                next_cycle();
                ls_req_i = 0;
            end
        end
        check("t4_req_cycles", n_req, 4);
        check("t4_gnt_pulses", n_gnt, 1);
        gnt_delay = 0;
        ls_we_i = 0;
        wait_idle("t4_idle");

        // Reset in WAIT, then a stray response after release
        next_cycle();
        auto_resp = 0;
        ls_req_i = 1; ls_be_i = 4'hF; ls_addr_i = 32'h700;
        next_cycle();
        man_gnt = 1;
        @(negedge clk);
        check("t5_ls_gnt", ls_gnt_o, 1);
        next_cycle();
        man_gnt = 0; ls_req_i = 0;
        @(negedge clk);
        check("t5_busy_wait", busy_o, 1);
        next_cycle();
        rst_n = 0;
        @(negedge clk);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_addr", mem_addr_o, 32'h0);
        check("t5_rst_wdata", mem_wdata_o, 32'h0);
        next_cycle();
        rst_n = 1;
        next_cycle();
        man_rvalid = 1; man_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("t5_no_ls_rvalid", ls_rvalid_o, 0);
        check("t5_no_if_rvalid", if_rvalid_o, 0);
        check("t5_idle", busy_o, 0);
        next_cycle();
        man_rvalid = 0; man_rdata = '0;
        auto_resp = 1;
        next_cycle();

        // Back-to-back loads: one request every 2 cycles, busy never drops
        resp_data = 32'h55AA55AA;
        ls_req_i = 1; ls_we_i = 0; ls_be_i = 4'hF; ls_addr_i = 32'h800;
        saw_req = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req_o) begin
                saw_req = 1;
                break;
            end
        end
        check("t6_first_req", saw_req, 1);
        for (int k = 0; k < 8; k++) begin
            check("t6_req_pattern", mem_req_o, (k % 2 == 0));
            check("t6_busy", busy_o, 1);
            @(negedge clk);
        end
        next_cycle();
        ls_req_i = 0;
        wait_idle("t6_idle");

        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
